// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares one synchronous single-port RAM between a high-priority requester A
// (video fetch) and a low-priority requester B (CPU). At most one access is
// accepted per clock. The RAM command is driven from registers, and read data
// is routed back to the requester that issued the read.
//
// A starvation counter tracks how many arbitrations B has lost in a row. When
// it reaches STARVE_LIMIT, B wins exactly one transfer. STARVE_LIMIT = 0
// disables the override and gives pure fixed priority.
//
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata       requester A command (held until a_gnt)
//   a_gnt                           combinational: A accepted at this edge
//   a_rvalid/a_rdata                A read return (rdata is 0 when not valid)
//   b_*                             same set of signals for requester B
//   ram_enable/ram_we/ram_a/ram_di  registered RAM command
//   ram_do                          RAM registered read data
//
// Optional build macro RAM_ARB_STATS_EN adds three 16-bit wrapping counters:
//   stat_a    A transfers
//   stat_b    B transfers
//   stat_ovr  grants made by the starvation override
// ---------------------------------------------------------------------------
module ram_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  ram_enable,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic [DATA_WIDTH-1:0] ram_di,
   input  logic [DATA_WIDTH-1:0] ram_do
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [15:0]           stat_a,
   output logic [15:0]           stat_b,
   output logic [15:0]           stat_ovr
`endif
);

   localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

   // Read-owner tag. It travels with the command, then with the RAM output.
   typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;

   logic                  override;
   logic                  ram_enable_q, ram_enable_d;
   logic                  ram_we_q,     ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_a_q,      ram_a_d;
   logic [DATA_WIDTH-1:0] ram_di_q,     ram_di_d;
   owner_e                cmd_owner_q,  cmd_owner_d;  // read tag for the command now on ram_*
   owner_e                ret_owner_q,  ret_owner_d;  // read tag for the data now on ram_do
   logic [7:0]            starve_cnt_q, starve_cnt_d;
`ifdef RAM_ARB_STATS_EN
   logic [15:0]           stat_a_q,   stat_a_d;
   logic [15:0]           stat_b_q,   stat_b_d;
   logic [15:0]           stat_ovr_q, stat_ovr_d;
`endif

   // Selection. B wins when A is idle, or when B has lost too many arbitrations in a row.
   always_comb begin
      override = (STARVE_LIMIT != 0) && b_req && (starve_cnt_q >= STARVE_LIM8);
      b_gnt    = b_req && (!a_req || override);
      a_gnt    = a_req && !b_gnt;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      ram_enable_d = 1'b0;
      ram_we_d     = 1'b0;
      ram_a_d      = '0;
      ram_di_d     = '0;
      cmd_owner_d  = OWN_NONE;
      if (a_gnt) begin
         ram_enable_d = 1'b1;
         ram_we_d     = a_we;
         ram_a_d      = a_addr;
         ram_di_d     = a_wdata;
         cmd_owner_d  = a_we ? OWN_NONE : OWN_A;
      end else if (b_gnt) begin
         ram_enable_d = 1'b1;
         ram_we_d     = b_we;
         ram_a_d      = b_addr;
         ram_di_d     = b_wdata;
         cmd_owner_d  = b_we ? OWN_NONE : OWN_B;
      end

      // The RAM samples the command at the next edge, so the tag advances with it.
      ret_owner_d = cmd_owner_q;

      // Count consecutive lost arbitrations, saturating so a long A burst never wraps.
      if (b_req && !b_gnt) begin
         starve_cnt_d = (starve_cnt_q == 8'hFF) ? starve_cnt_q : starve_cnt_q + 8'd1;
      end else begin
         starve_cnt_d = '0;
      end

`ifdef RAM_ARB_STATS_EN
      stat_a_d   = a_gnt    ? stat_a_q   + 16'd1 : stat_a_q;
      stat_b_d   = b_gnt    ? stat_b_q   + 16'd1 : stat_b_q;
      stat_ovr_d = override ? stat_ovr_q + 16'd1 : stat_ovr_q;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: clearing both owner stages on reset drops any read still in flight.
      if (!reset_n) begin
         ram_enable_q <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_a_q      <= '0;
         ram_di_q     <= '0;
         cmd_owner_q  <= OWN_NONE;
         ret_owner_q  <= OWN_NONE;
         starve_cnt_q <= '0;
`ifdef RAM_ARB_STATS_EN
         stat_a_q     <= '0;
         stat_b_q     <= '0;
         stat_ovr_q   <= '0;
`endif
      end else begin
         // NOTE: non-blocking updates keep every flop sampling pre-edge values.
         ram_enable_q <= ram_enable_d;
         ram_we_q     <= ram_we_d;
         ram_a_q      <= ram_a_d;
         ram_di_q     <= ram_di_d;
         cmd_owner_q  <= cmd_owner_d;
         ret_owner_q  <= ret_owner_d;
         starve_cnt_q <= starve_cnt_d;
`ifdef RAM_ARB_STATS_EN
         stat_a_q     <= stat_a_d;
         stat_b_q     <= stat_b_d;
         stat_ovr_q   <= stat_ovr_d;
`endif
      end
   end

   assign ram_enable = ram_enable_q;
   assign ram_we     = ram_we_q;
   assign ram_a      = ram_a_q;
   assign ram_di     = ram_di_q;

   assign a_rvalid = (ret_owner_q == OWN_A);
   assign b_rvalid = (ret_owner_q == OWN_B);
   assign a_rdata  = a_rvalid ? ram_do : '0;
   assign b_rdata  = b_rvalid ? ram_do : '0;

`ifdef RAM_ARB_STATS_EN
   assign stat_a   = stat_a_q;
   assign stat_b   = stat_b_q;
   assign stat_ovr = stat_ovr_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Scoreboard bench for ram_arbiter.
//
// A reference model at negedge predicts the grants, the registered RAM command
// and the read data from the arbitration rules and a flat model memory. Each
// predicted read is queued with the cycle it is due. A separate monitor pops
// the queue and compares a/b rvalid and rdata. A behavioural RAM sits on the
// ram_* port. A second instance with STARVE_LIMIT = 0 checks pure fixed
// priority under a long A burst.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_arbiter;

   localparam int AW    = 16;
   localparam int DW    = 8;
   localparam int LIMIT = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // Main DUT signals
   logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          ram_enable, ram_we;
   logic [AW-1:0] ram_a;
   logic [DW-1:0] ram_di;
   logic [DW-1:0] ram_do = '0;

   // Fixed-priority instance signals
   logic          z_a_req = 1'b0, z_b_req = 1'b0;
   logic          z_we = 1'b0;
   logic [AW-1:0] z_addr = '0;
   logic [DW-1:0] z_wdata = '0;
   logic [DW-1:0] z_ram_do = '0;
   logic          z_a_gnt, z_b_gnt, z_a_rvalid, z_b_rvalid, z_ram_enable, z_ram_we;
   logic [DW-1:0] z_a_rdata, z_b_rdata, z_ram_di;
   logic [AW-1:0] z_ram_a;
   bit            z_active = 1'b0;

`ifdef RAM_ARB_STATS_EN
   logic [15:0] stat_a, stat_b, stat_ovr;
   logic [15:0] z_stat_a, z_stat_b, z_stat_ovr;
   logic [15:0] ref_sa = '0, ref_sb = '0, ref_so = '0;
`endif

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .a_req      (a_req),
      .a_we       (a_we),
      .a_addr     (a_addr),
      .a_wdata    (a_wdata),
      .a_gnt      (a_gnt),
      .a_rvalid   (a_rvalid),
      .a_rdata    (a_rdata),
      .b_req      (b_req),
      .b_we       (b_we),
      .b_addr     (b_addr),
      .b_wdata    (b_wdata),
      .b_gnt      (b_gnt),
      .b_rvalid   (b_rvalid),
      .b_rdata    (b_rdata),
      .ram_enable (ram_enable),
      .ram_we     (ram_we),
      .ram_a      (ram_a),
      .ram_di     (ram_di),
      .ram_do     (ram_do)
`ifdef RAM_ARB_STATS_EN
      ,
      .stat_a     (stat_a),
      .stat_b     (stat_b),
      .stat_ovr   (stat_ovr)
`endif
   );

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0)) u_fixed (
      .clk        (clk),
      .reset_n    (reset_n),
      .a_req      (z_a_req),
      .a_we       (z_we),
      .a_addr     (z_addr),
      .a_wdata    (z_wdata),
      .a_gnt      (z_a_gnt),
      .a_rvalid   (z_a_rvalid),
      .a_rdata    (z_a_rdata),
      .b_req      (z_b_req),
      .b_we       (z_we),
      .b_addr     (z_addr),
      .b_wdata    (z_wdata),
      .b_gnt      (z_b_gnt),
      .b_rvalid   (z_b_rvalid),
      .b_rdata    (z_b_rdata),
      .ram_enable (z_ram_enable),
      .ram_we     (z_ram_we),
      .ram_a      (z_ram_a),
      .ram_di     (z_ram_di),
      .ram_do     (z_ram_do)
`ifdef RAM_ARB_STATS_EN
      ,
      .stat_a     (z_stat_a),
      .stat_b     (z_stat_b),
      .stat_ovr   (z_stat_ovr)
`endif
   );

   // Behavioural synchronous RAM: registered read data, 0 when not reading.
   logic [DW-1:0] ram_mem [0:65535];
   always @(posedge clk) begin
      if (ram_enable && ram_we) ram_mem[ram_a] <= ram_di;
      ram_do <= (ram_enable && !ram_we) ? ram_mem[ram_a] : '0;
   end

   // Bookkeeping
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model
   typedef struct {
      int            due;
      bit            own_b;
      logic [DW-1:0] data;
   } rd_t;
   rd_t           sb_q[$];
   logic [DW-1:0] ref_mem [0:65535];
   int            ref_lost = 0;
   logic          exp_en = 1'b0, exp_we = 1'b0;
   logic [AW-1:0] exp_a  = '0;
   logic [DW-1:0] exp_di = '0;
   bit            m_ovr, m_ea, m_eb;

   always @(negedge clk) begin
      if (reset_n) begin
         // Command registered from the previous cycle's predicted transfer
         check("ram_enable", ram_enable, exp_en);
         check("ram_we", ram_we, exp_we);
         check("ram_a", ram_a, exp_a);
         check("ram_di", ram_di, exp_di);
`ifdef RAM_ARB_STATS_EN
         check("stat_a", stat_a, ref_sa);
         check("stat_b", stat_b, ref_sb);
         check("stat_ovr", stat_ovr, ref_so);
`endif
         // B gets the RAM if A is idle or B has already lost LIMIT times running.
         m_ovr = (LIMIT != 0) && b_req && (ref_lost >= LIMIT);
         m_eb  = b_req && (!a_req || m_ovr);
         m_ea  = a_req && !m_eb;
         check("a_gnt", a_gnt, m_ea);
         check("b_gnt", b_gnt, m_eb);

         exp_en = m_ea || m_eb;
         exp_we = 1'b0; exp_a = '0; exp_di = '0;
         if (m_ea) begin
            exp_we = a_we; exp_a = a_addr; exp_di = a_wdata;
         end else if (m_eb) begin
            exp_we = b_we; exp_a = b_addr; exp_di = b_wdata;
         end
         if (exp_en) begin
            if (exp_we) ref_mem[exp_a] = exp_di;
            else sb_q.push_back('{due: cyc + 2, own_b: m_eb, data: ref_mem[exp_a]});
         end
         if (b_req && !m_eb) ref_lost = (ref_lost < 255) ? ref_lost + 1 : 255;
         else ref_lost = 0;
`ifdef RAM_ARB_STATS_EN
         if (m_ea) ref_sa++;
         if (m_eb) ref_sb++;
         if (m_ovr) ref_so++;
`endif
      end
   end

   // Monitor: read returns against the queue
   rd_t           mon_e;
   logic          mon_av, mon_bv;
   logic [DW-1:0] mon_ad, mon_bd;
   always @(negedge clk) begin
      if (reset_n) begin
         mon_av = 1'b0; mon_bv = 1'b0; mon_ad = '0; mon_bd = '0;
         if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            checks++; failures++;
            $display("FAIL rd_timeout: read due cycle %0d not returned by cycle %0d", sb_q[0].due, cyc);
            void'(sb_q.pop_front());
         end
         if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.own_b) begin mon_bv = 1'b1; mon_bd = mon_e.data; end
            else begin mon_av = 1'b1; mon_ad = mon_e.data; end
         end
         check("a_rvalid", a_rvalid, mon_av);
         check("b_rvalid", b_rvalid, mon_bv);
         check("a_rdata", a_rdata, mon_ad);
         check("b_rdata", b_rdata, mon_bd);
      end
   end

   // Fixed-priority instance: B never wins while A requests.
   always @(negedge clk) begin
      if (reset_n && z_active) begin
         check("fixed_b_gnt", z_b_gnt, 1'b0);
         check("fixed_a_gnt", z_a_gnt, 1'b1);
      end
   end

   task automatic idle();
      a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
   endtask

   task automatic rand_cycle();
      a_req   = ($urandom_range(0, 99) < 55);
      b_req   = ($urandom_range(0, 99) < 55);
      a_we    = $urandom_range(0, 1);
      b_we    = $urandom_range(0, 1);
      a_addr  = AW'($urandom_range(0, 15));
      b_addr  = AW'($urandom_range(0, 15));
      a_wdata = DW'($urandom);
      b_wdata = DW'($urandom);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // B alone: write 0x5A to 0x1234, then read it back
      @(posedge clk); #1
      b_req = 1'b1; b_we = 1'b1; b_addr = 16'h1234; b_wdata = 8'h5A;
      @(posedge clk); #1 b_we = 1'b0;
      @(posedge clk); #1 idle();
      repeat (3) @(posedge clk);

      // Simultaneous reads: A first, B once A drops
      #1 a_req = 1'b1; a_addr = 16'h1234; b_req = 1'b1; b_addr = 16'h0007;
      @(posedge clk); #1 a_req = 1'b0;
      for (int i = 0; i < 10 && !b_gnt; i++) @(posedge clk);
      #1 idle();
      @(posedge clk);

      // Back-to-back A writes then reads at 0,1,2 with a_req held
      for (int i = 0; i < 3; i++) begin
         #1 a_req = 1'b1; a_we = 1'b1; a_addr = AW'(i); a_wdata = DW'(8'hC0 + i);
         @(posedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         #1 a_we = 1'b0; a_addr = AW'(i);
         @(posedge clk);
      end
      #1 idle();
      @(posedge clk);

      // Both continuous: B must win every 5th arbitration
      for (int i = 0; i < 20; i++) begin
         #1 a_req = 1'b1; b_req = 1'b1;
         a_we = 1'b0; b_we = $urandom_range(0, 1);
         a_addr = AW'($urandom_range(0, 15)); b_addr = AW'($urandom_range(0, 15));
         b_wdata = DW'($urandom);
         @(negedge clk);
         check("ovr_pattern", b_gnt, (i % 5 == 4));
         @(posedge clk);
      end
      #1 idle();
      @(posedge clk);

      // Randomized traffic; fixed-priority instance runs 300 cycles alongside
      #1 z_a_req = 1'b1; z_b_req = 1'b1; z_active = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if (i == 300) begin
            z_active = 1'b0; z_a_req = 1'b0; z_b_req = 1'b0;
         end
         rand_cycle();
         @(posedge clk); #1;
      end
      idle();
      repeat (3) @(posedge clk);

      // Reset one cycle after an A read accept: the read is never reported
      #1 a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0003;
      @(posedge clk); #1 a_req = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("rst_ram_enable", ram_enable, 1'b0);
      check("rst_ram_we", ram_we, 1'b0);
      check("rst_ram_a", ram_a, 16'h0000);
      check("rst_ram_di", ram_di, 8'h00);
      check("rst_a_rvalid", a_rvalid, 1'b0);
      sb_q.delete();
      exp_en = 1'b0; exp_we = 1'b0; exp_a = '0; exp_di = '0;
      ref_lost = 0;
`ifdef RAM_ARB_STATS_EN
      ref_sa = '0; ref_sb = '0; ref_so = '0;
`endif
      @(posedge clk); #1 reset_n = 1'b1;

      // Normal operation after release
      for (int i = 0; i < 300; i++) begin
         rand_cycle();
         @(posedge clk); #1;
      end
      idle();
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
